// File: rtl/ram_bus_responder.sv
// Target side of the byte-serial RAM bus: on-chip RAM plus a small I/O region
// holding the TX byte FIFO, status byte, sticky halt flag and coherent cycle counter.
module ram_bus_responder #(
   parameter int RAM_AW        = 17,
   parameter int TX_DEPTH_LOG2 = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ram_rw,
   input  logic [31:0] ram_addr,
   input  logic [7:0]  ram_w_data,
   output logic [7:0]  ram_r_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halt
);

   localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;

   logic [7:0]               mem [0:(1 << RAM_AW) - 1];
   logic [7:0]               storage [0:TX_DEPTH - 1];
   logic [TX_DEPTH_LOG2-1:0] wr_ptr;
   logic [TX_DEPTH_LOG2-1:0] rd_ptr;
   logic [TX_DEPTH_LOG2:0]   count;
   logic                     overflow;
   logic [31:0]              cycle_cnt;
   logic [23:0]              snap;

   logic                     io_sel;
   logic [3:0]               offset;
   logic [RAM_AW-1:0]        index;
   logic                     push_req;
   logic                     push_ok;
   logic                     pop;
   logic                     full;
   logic                     empty;
   logic                     halt_set;
   logic                     snap_load;
   logic [7:0]               occupancy;
   logic [7:0]               io_r_data;
   logic                     unused_addr_bits;

   assign io_sel           = (ram_addr[17:16] == 2'b11);
   assign offset           = ram_addr[3:0];
   assign index            = ram_addr[RAM_AW-1:0];
   assign unused_addr_bits = ^ram_addr[31:18];

   assign full      = (count == (TX_DEPTH_LOG2 + 1)'(TX_DEPTH));
   assign empty     = (count == '0);
   assign pop       = tx_valid && tx_ready;
   assign push_req  = ram_rw && io_sel && (offset == 4'h0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok   = push_req && (!full || pop);
   assign halt_set  = ram_rw && io_sel && (offset == 4'h4);
   assign snap_load = !ram_rw && io_sel && (offset == 4'h8);

   assign tx_valid = !empty;
   assign tx_data  = storage[rd_ptr];

   assign occupancy = (32'(count) > 32'd255) ? 8'hFF : 8'(count);

   always_comb begin
      io_r_data = '0;
      case (offset)
         4'h0:    io_r_data = occupancy;
         4'h4:    io_r_data = {5'b0, overflow, full, empty};
         4'h8:    io_r_data = cycle_cnt[7:0];
         4'h9:    io_r_data = snap[7:0];
         4'hA:    io_r_data = snap[15:8];
         4'hB:    io_r_data = snap[23:16];
         default: io_r_data = '0;
      endcase
   end

   // Read-before-write: the read register samples the old RAM byte on a write cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         ram_r_data <= '0;
      end else begin
         ram_r_data <= io_sel ? io_r_data : mem[index];
      end
   end

   always_ff @(posedge clock) begin
      if (ram_rw && !io_sel) begin
         mem[index] <= ram_w_data;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) begin
         storage[wr_ptr] <= ram_w_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_req && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         halt      <= 1'b0;
         cycle_cnt <= '0;
         snap      <= '0;
      end else begin
         if (halt_set) begin
            halt <= 1'b1;
         end
         if (!halt) begin
            cycle_cnt <= cycle_cnt + 32'd1;
         end
         if (snap_load) begin
            snap <= cycle_cnt[31:8];
         end
      end
   end

endmodule
